// File: rtl/psg_registers.sv
// psg_registers: bus interface and register file of the PSG.
//   Decodes AY-3-8913 BDIR/BC1 bus cycles, latches the register address,
//   and holds control registers R0-R13. Register fields fan out to the tone,
//   noise and envelope generators and the amplitude stage.
//
// Parameters:
//   CHIP_ADDR    data_in[7:4] value that selects this chip during address latch.
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   bdir, bc1           bus mode: 00 idle, 01 read, 10 write, 11 latch address
//   data_in             address or write data
//   data_out            read data (registered)
//   data_out_en         read data valid / drive enable
//   tone_period_a/b/c   {coarse[3:0], fine[7:0]}
//   noise_period        R6[4:0]
//   mixer               R7
//   amp_a/b/c           R8-R10[4:0]; bit 4 selects envelope mode
//   envelope_period     {R12, R11}
//   env_continue/attack/alternate/hold  R13[3:0]
//   envelope_restart    one-cycle pulse following each R13 write cycle
//
// Build option: define PSG_READBACK_EN to enable the read path. When it is
// undefined, mode 01 is treated as inactive and data_out/data_out_en are 0.
module psg_registers #(
  parameter logic [3:0] CHIP_ADDR = 4'b0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bdir,
  input  logic        bc1,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        data_out_en,
  output logic [11:0] tone_period_a,
  output logic [11:0] tone_period_b,
  output logic [11:0] tone_period_c,
  output logic [4:0]  noise_period,
  output logic [7:0]  mixer,
  output logic [4:0]  amp_a,
  output logic [4:0]  amp_b,
  output logic [4:0]  amp_c,
  output logic [15:0] envelope_period,
  output logic        env_continue,
  output logic        env_attack,
  output logic        env_alternate,
  output logic        env_hold,
  output logic        envelope_restart
);

  typedef enum logic [1:0] {
    BUS_IDLE  = 2'b00,
    BUS_READ  = 2'b01,
    BUS_WRITE = 2'b10,
    BUS_LATCH = 2'b11
  } bus_mode_t;

  bus_mode_t   mode;
  logic [3:0]  addr;
  logic        selected;
  logic [7:0]  regs [14];

  assign mode = bus_mode_t'({bdir, bc1});

  // Bits beyond each register's field width are never stored, so the
  // register contents are always the masked value.
  function automatic logic [7:0] field_mask(input logic [3:0] a);
    case (a)
      4'd1, 4'd3, 4'd5, 4'd13: field_mask = 8'h0F;
      4'd6, 4'd8, 4'd9, 4'd10: field_mask = 8'h1F;
      4'd14, 4'd15:            field_mask = 8'h00;
      default:                 field_mask = 8'hFF;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      addr             <= '0;
      selected         <= 1'b1;
      envelope_restart <= 1'b0;
      for (int unsigned i = 0; i < 14; i++) regs[i] <= '0;
    end else begin
      envelope_restart <= 1'b0;
      case (mode)
        BUS_LATCH: begin
          addr     <= data_in[3:0];
          selected <= (data_in[7:4] == CHIP_ADDR);
        end
        BUS_WRITE: begin
          if (selected) begin
            for (int unsigned i = 0; i < 14; i++) begin
              if (addr == 4'(i)) regs[i] <= data_in & field_mask(addr);
            end
            envelope_restart <= (addr == 4'd13);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PSG_READBACK_EN
  logic [7:0] read_value;

  // Addresses 14/15 match no entry and read as 0.
  always_comb begin
    read_value = '0;
    for (int unsigned i = 0; i < 14; i++) begin
      if (addr == 4'(i)) read_value = regs[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out    <= '0;
      data_out_en <= 1'b0;
    end else if (mode == BUS_READ) begin
      data_out    <= selected ? read_value : '0;
      data_out_en <= 1'b1;
    end else begin
      data_out    <= '0;
      data_out_en <= 1'b0;
    end
  end
`else
  assign data_out    = '0;
  assign data_out_en = 1'b0;
`endif

  assign tone_period_a   = {regs[1][3:0], regs[0]};
  assign tone_period_b   = {regs[3][3:0], regs[2]};
  assign tone_period_c   = {regs[5][3:0], regs[4]};
  assign noise_period    = regs[6][4:0];
  assign mixer           = regs[7];
  assign amp_a           = regs[8][4:0];
  assign amp_b           = regs[9][4:0];
  assign amp_c           = regs[10][4:0];
  assign envelope_period = {regs[12], regs[11]};
  assign env_continue    = regs[13][3];
  assign env_attack      = regs[13][2];
  assign env_alternate   = regs[13][1];
  assign env_hold        = regs[13][0];

  // Masked-off register bits are constant 0; gathered here so they are
  // visibly accounted for when the read mux is not built.
  logic unused_bits;
  assign unused_bits = ^{regs[1][7:4], regs[3][7:4], regs[5][7:4],
                         regs[6][7:5], regs[8][7:5], regs[9][7:5],
                         regs[10][7:5], regs[13][7:4]};

endmodule

// File: tb/tb_psg_registers.sv
module tb_psg_registers;

  logic        clk = 1'b0;
  logic        reset;
  logic        bdir;
  logic        bc1;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        data_out_en;
  logic [11:0] tone_period_a, tone_period_b, tone_period_c;
  logic [4:0]  noise_period;
  logic [7:0]  mixer;
  logic [4:0]  amp_a, amp_b, amp_c;
  logic [15:0] envelope_period;
  logic        env_continue, env_attack, env_alternate, env_hold;
  logic        envelope_restart;

  int checks = 0;
  int errors = 0;

`ifdef PSG_READBACK_EN
  localparam bit READBACK = 1'b1;
`else
  localparam bit READBACK = 1'b0;
`endif

  psg_registers #(.CHIP_ADDR(4'b0000)) dut (
    .clk              (clk),
    .reset            (reset),
    .bdir             (bdir),
    .bc1              (bc1),
    .data_in          (data_in),
    .data_out         (data_out),
    .data_out_en      (data_out_en),
    .tone_period_a    (tone_period_a),
    .tone_period_b    (tone_period_b),
    .tone_period_c    (tone_period_c),
    .noise_period     (noise_period),
    .mixer            (mixer),
    .amp_a            (amp_a),
    .amp_b            (amp_b),
    .amp_c            (amp_c),
    .envelope_period  (envelope_period),
    .env_continue     (env_continue),
    .env_attack       (env_attack),
    .env_alternate    (env_alternate),
    .env_hold         (env_hold),
    .envelope_restart (envelope_restart)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Apply one bus cycle; returns 1 time unit after the sampling edge.
  task automatic step(input logic [1:0] m, input logic [7:0] d);
    {bdir, bc1} = m;
    data_in     = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_read(input string tag, input logic [7:0] value);
    step(2'b01, 8'h00);
    check({tag, "_data"}, 32'(data_out), READBACK ? 32'(value) : 32'h0);
    check({tag, "_en"}, 32'(data_out_en), READBACK ? 32'h1 : 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    {bdir, bc1} = 2'b00;
    data_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    check("rst_tone_a", 32'(tone_period_a), 32'h0);
    check("rst_tone_b", 32'(tone_period_b), 32'h0);
    check("rst_tone_c", 32'(tone_period_c), 32'h0);
    check("rst_noise", 32'(noise_period), 32'h0);
    check("rst_mixer", 32'(mixer), 32'h0);
    check("rst_amps", 32'({amp_a, amp_b, amp_c}), 32'h0);
    check("rst_envp", 32'(envelope_period), 32'h0);
    check("rst_shape", 32'({env_continue, env_attack, env_alternate, env_hold}), 32'h0);
    check("rst_restart", 32'(envelope_restart), 32'h0);
    check("rst_dout", 32'(data_out), 32'h0);
    check("rst_dout_en", 32'(data_out_en), 32'h0);

    // Reset leaves the chip selected with addr 0: a write lands in R0.
    step(2'b10, 8'h12);
    check("sel_after_reset", 32'(tone_period_a), 32'h012);
    step(2'b10, 8'h00);

    for (int i = 0; i < 14; i++) begin
      step(2'b11, 8'(i));
      check_read($sformatf("rst_read_r%0d", i), 8'h00);
    end
    step(2'b00, 8'h00);
    check("idle_dout_en", 32'(data_out_en), 32'h0);

    // Tone A with coarse masking
    step(2'b11, 8'h01);
    step(2'b10, 8'hFF);
    step(2'b11, 8'h00);
    step(2'b10, 8'h34);
    check("tone_a", 32'(tone_period_a), 32'hF34);
    step(2'b11, 8'h01);
    check_read("read_r1_masked", 8'h0F);
    step(2'b01, 8'h00);
    check("read_held", 32'(data_out), READBACK ? 32'h0F : 32'h0);
    step(2'b00, 8'h00);
    check("read_end_en", 32'(data_out_en), 32'h0);
    check("read_end_data", 32'(data_out), 32'h0);

    // Other field widths
    step(2'b11, 8'h06);
    step(2'b10, 8'hFF);
    check("noise_masked", 32'(noise_period), 32'h1F);
    check_read("read_r6", 8'h1F);
    step(2'b11, 8'h07);
    step(2'b10, 8'hC3);
    check("mixer", 32'(mixer), 32'hC3);
    step(2'b11, 8'h0B);
    step(2'b10, 8'h78);
    step(2'b11, 8'h0C);
    step(2'b10, 8'h9A);
    check("env_period", 32'(envelope_period), 32'h9A78);
    check_read("read_after_write", 8'h9A);
    step(2'b11, 8'h05);
    step(2'b10, 8'hE7);
    check("tone_c_masked", 32'(tone_period_c), 32'h700);

    // Envelope shape write and restart pulse
    step(2'b11, 8'h0D);
    check("restart_before", 32'(envelope_restart), 32'h0);
    step(2'b10, 8'h0E);
    check("shape", 32'({env_continue, env_attack, env_alternate, env_hold}), 32'hE);
    check("restart_pulse", 32'(envelope_restart), 32'h1);
    step(2'b00, 8'h00);
    check("restart_single", 32'(envelope_restart), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(2'b10, 8'hF5);
      check($sformatf("restart_held_%0d", i), 32'(envelope_restart), 32'h1);
    end
    check("shape_masked", 32'({env_continue, env_attack, env_alternate, env_hold}), 32'h5);
    step(2'b00, 8'h00);
    check("restart_held_end", 32'(envelope_restart), 32'h0);

    // Chip-address mismatch deselects
    step(2'b11, 8'h18);
    step(2'b10, 8'hAA);
    check("desel_amp_a", 32'(amp_a), 32'h00);
    check("desel_restart", 32'(envelope_restart), 32'h0);
    check_read("desel_read", 8'h00);
    step(2'b11, 8'h08);
    step(2'b10, 8'hAA);
    check("amp_a", 32'(amp_a), 32'h0A);
    check_read("read_r8", 8'h0A);
    step(2'b11, 8'h0A);
    step(2'b10, 8'hFF);
    check("amp_c_env_mode", 32'(amp_c), 32'h1F);

    // Addresses 14/15 are absent
    step(2'b11, 8'h0E);
    step(2'b10, 8'h55);
    check("r14_tone_a", 32'(tone_period_a), 32'hF34);
    check("r14_amp_a", 32'(amp_a), 32'h0A);
    check("r14_mixer", 32'(mixer), 32'hC3);
    check("r14_restart", 32'(envelope_restart), 32'h0);
    check_read("read_r14", 8'h00);
    step(2'b11, 8'h0F);
    check_read("read_r15", 8'h00);

    // Reset overrides a concurrent R13 write
    step(2'b11, 8'h0D);
    reset = 1'b1;
    step(2'b10, 8'h0F);
    check("rst_wr_restart", 32'(envelope_restart), 32'h0);
    check("rst_wr_shape", 32'({env_continue, env_attack, env_alternate, env_hold}), 32'h0);
    check("rst_wr_amp_a", 32'(amp_a), 32'h0);
    reset = 1'b0;
    step(2'b00, 8'h00);
    check("rst_wr_restart2", 32'(envelope_restart), 32'h0);
    check_read("post_rst_read_r0", 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
